key_schedule_ctrl: RTL and testbench

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/des_pkg.sv | 51 +++++
 rtl/key_schedule_ctrl_if.sv | 29 ++
 rtl/des_pc2.sv | 25 ++
 rtl/key_schedule_ctrl.sv | 101 ++++++++++
 tb/tb_key_schedule_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Package : des_pkg
// Purpose : Shared DES key-schedule constants, FSM encoding and rotate helpers.
// Revision: 1.0
// ============================================================================
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    // Encrypt-direction left-rotate amounts for rounds 0..15.
    localparam logic [1:0] c_shift_sched [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // DES bit numbers (1 = C1, 56 = D28) selected for subkey bits 1..48.
    localparam int c_pc2_tbl [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [28:1] rotl28(input logic [28:1] x, input logic [1:0] n);
        logic [28:1] r;
        case (n)
            2'd1:    r = {x[27:1], x[28]};
            2'd2:    r = {x[26:1], x[28:27]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [28:1] rotr28(input logic [28:1] x, input logic [1:0] n);
        logic [28:1] r;
        case (n)
            2'd1:    r = {x[1], x[28:2]};
            2'd2:    r = {x[2:1], x[28:3]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_schedule_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : key_schedule_ctrl_if
// Purpose   : Request / subkey handshake bundle of the DES key scheduler.
// Revision  : 1.0
// ============================================================================
interface key_schedule_ctrl_if;
    logic        START;
    logic        DECRYPT;
    logic [28:1] C_IN;
    logic [28:1] D_IN;
    logic        ROUND_READY;
    logic [48:1] ROUND_KEY;
    logic        ROUND_KEY_VALID;
    logic [3:0]  ROUND_NUM;
    logic        BUSY;
    logic        DONE;

    modport master (
        output START, DECRYPT, C_IN, D_IN, ROUND_READY,
        input  ROUND_KEY, ROUND_KEY_VALID, ROUND_NUM, BUSY, DONE
    );

    modport slave (
        input  START, DECRYPT, C_IN, D_IN, ROUND_READY,
        output ROUND_KEY, ROUND_KEY_VALID, ROUND_NUM, BUSY, DONE
    );
endinterface
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module  : des_pc2
// Purpose : Combinational DES Permuted Choice 2 (56-bit C||D -> 48-bit key).
// Revision: 1.0
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [56:1] i_cd,
    output logic [48:1] o_key
);

    // Vector index 57-n holds DES bit n, so bit 1 lands on the MSB.
    for (genvar gi = 1; gi <= 48; gi++) begin : g_pc2
        assign o_key[49-gi] = i_cd[57-c_pc2_tbl[gi-1]];
    end

    // DES bits 9,18,22,25,35,38,43,54 are discarded by PC-2.
    logic w_unused;
    assign w_unused = ^{i_cd[48], i_cd[39], i_cd[35], i_cd[32],
                        i_cd[22], i_cd[19], i_cd[14], i_cd[3]};

endmodule
`default_nettype wire

// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : key_schedule_ctrl
// Purpose : Sequences 16 DES subkeys (either direction) over a ready handshake.
// Revision: 1.0
// ============================================================================
module key_schedule_ctrl
    import des_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    key_schedule_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic [28:1] c_q, c_d;
    logic [28:1] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        decrypt_q, decrypt_d;

    logic [3:0]  w_dec_idx;
    logic [1:0]  w_amt;
    logic [48:1] w_pc2_key;
    logic        w_valid;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            d_q       <= '0;
            round_q   <= '0;
            decrypt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            round_q   <= round_d;
            decrypt_q <= decrypt_d;
        end
    end

    // Decrypt round r undoes encrypt round 16-r; round 0 starts from C16=C0.
    assign w_dec_idx = 4'd0 - round_q;
    assign w_amt     = decrypt_q ? ((round_q == 4'd0) ? 2'd0 : c_shift_sched[w_dec_idx])
                                 : c_shift_sched[round_q];

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        round_d   = round_q;
        decrypt_d = decrypt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    c_d       = bus.C_IN;
                    d_d       = bus.D_IN;
                    decrypt_d = bus.DECRYPT;
                    round_d   = 4'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (decrypt_q) begin
                    c_d = rotr28(c_q, w_amt);
                    d_d = rotr28(d_q, w_amt);
                end else begin
                    c_d = rotl28(c_q, w_amt);
                    d_d = rotl28(d_q, w_amt);
                end
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.ROUND_READY) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_FINISH;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    des_pc2 u_pc2 (
        .i_cd  ({c_q, d_q}),
        .o_key (w_pc2_key)
    );

    assign w_valid             = (state_q == ST_PRESENT);
    assign bus.ROUND_KEY_VALID = w_valid;
    assign bus.ROUND_KEY       = w_valid ? w_pc2_key : '0;
    assign bus.ROUND_NUM       = w_valid ? round_q : 4'd0;
    assign bus.BUSY            = (state_q != ST_IDLE);
    assign bus.DONE            = (state_q == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_schedule_ctrl
// Purpose : Self-checking bench for key_schedule_ctrl (vectors + random model).
// Revision: 1.0
// ============================================================================
module tb_key_schedule_ctrl;

    localparam int c_pc2_ref [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int c_shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct {
        logic        dec;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k0;
        logic [47:0] k15;
        int          done_cyc;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs [4];

    key_schedule_ctrl_if bus ();

    key_schedule_ctrl dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [27:0] rot_ref(input logic [27:0] x, input int n);
        logic [55:0] t;
        t = {x, x} << (n % 28);
        return t[55:28];
    endfunction

    function automatic logic [47:0] pc2_ref(input logic [55:0] cd);
        logic [47:0] k;
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-c_pc2_ref[i]];
        return k;
    endfunction

    // Subkey Kn uses C0/D0 rotated left by the cumulative shift total up to n;
    // decryption simply consumes K16..K1.
    function automatic logic [47:0] model_key(input logic [27:0] c, input logic [27:0] d,
                                              input logic dec, input int r);
        int idx;
        int s;
        idx = dec ? 15 - r : r;
        s = 0;
        for (int j = 0; j <= idx; j++) s += c_shifts[j];
        return pc2_ref({rot_ref(c, s), rot_ref(d, s)});
    endfunction

    // mode 0: ready always high; 1: random ready and START/input noise while busy;
    // 2: ready held low for 5 cycles while round 3 is presented.
    task automatic run_sched(input logic dec, input logic [27:0] c, input logic [27:0] d,
                             input int mode, output logic [47:0] k0, output logic [47:0] k15,
                             output int done_cyc);
        int          cyc, next_round, last_acc, stalls, busy_cnt, bad_key, stall3;
        logic        prev_hold, rdy, finished;
        logic [47:0] prev_key;
        logic [3:0]  prev_num;
        @(negedge clk);
        check("idle_busy", bus.BUSY, 0);
        check("idle_valid", bus.ROUND_KEY_VALID, 0);
        bus.START = 1'b1; bus.DECRYPT = dec; bus.C_IN = c; bus.D_IN = d; bus.ROUND_READY = 1'b1;
        cyc = 0; next_round = 0; last_acc = 0; stalls = 0; busy_cnt = 0; bad_key = 0; stall3 = 0;
        prev_hold = 1'b0; finished = 1'b0; done_cyc = -1; k0 = '0; k15 = '0;
        prev_key = '0; prev_num = '0;
        while (!finished && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.START   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.C_IN    = 28'($urandom);
            bus.D_IN    = 28'($urandom);
            bus.DECRYPT = 1'($urandom_range(0, 1));
            if (bus.BUSY) busy_cnt++;
            if (prev_hold) begin
                check("hold_valid", bus.ROUND_KEY_VALID, 1);
                check("hold_key", bus.ROUND_KEY, prev_key);
                check("hold_num", bus.ROUND_NUM, prev_num);
            end
            if (bus.ROUND_KEY_VALID) begin
                if (!prev_hold) begin
                    check("latency", cyc - last_acc, 2);
                    check("round_num", bus.ROUND_NUM, next_round);
                    check("round_key", bus.ROUND_KEY, model_key(c, d, dec, next_round));
                    if (next_round == 0)  k0  = bus.ROUND_KEY;
                    if (next_round == 15) k15 = bus.ROUND_KEY;
                end
                if (mode == 1)      rdy = ($urandom_range(0, 3) != 0);
                else if (mode == 2) rdy = !(bus.ROUND_NUM == 4'd3 && stall3 < 5);
                else                rdy = 1'b1;
                bus.ROUND_READY = rdy;
                if (rdy) begin
                    last_acc = cyc; next_round++; prev_hold = 1'b0;
                end else begin
                    stalls++; if (mode == 2) stall3++;
                    prev_hold = 1'b1; prev_key = bus.ROUND_KEY; prev_num = bus.ROUND_NUM;
                end
            end else begin
                if (bus.ROUND_KEY != '0) bad_key++;
                bus.ROUND_READY = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                prev_hold = 1'b0;
            end
            if (bus.DONE) begin
                finished = 1'b1;
                done_cyc = cyc;
            end
        end
        bus.START = 1'b0;
        bus.ROUND_READY = 1'b0;
        check("timeout", finished, 1);
        check("rounds", next_round, 16);
        check("done_cycle", done_cyc, 33 + stalls);
        check("busy_cycles", busy_cnt, 33 + stalls);
        check("key_when_invalid", bad_key, 0);
        if (mode == 2) check("stall_cycles", stall3, 5);
    endtask

    initial begin
        logic [47:0] k0, k15;
        int          dcyc;
        logic        seen, stray;
        logic [27:0] rc, rd;
        logic        rdec;

        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{1'b0, 28'hF0CCAAF, 28'h556678F, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 33};
        vecs[1] = '{1'b1, 28'hF0CCAAF, 28'h556678F, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 33};
        vecs[2] = '{1'b0, 28'h0000000, 28'h0000000, 48'h000000000000, 48'h000000000000, 33};
        vecs[3] = '{1'b1, 28'hFFFFFFF, 28'hFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 33};

        // Reset with START held high: must stay idle with all outputs zero.
        rst = 1'b1;
        bus.START = 1'b1; bus.DECRYPT = 1'b0; bus.C_IN = '0; bus.D_IN = '0; bus.ROUND_READY = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.ROUND_KEY_VALID, 0);
        check("rst_key", bus.ROUND_KEY, 0);
        check("rst_num", bus.ROUND_NUM, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        rst = 1'b0;
        bus.START = 1'b0;

        // Directed vectors, run back to back (START in the IDLE cycle after FINISH).
        for (int i = 0; i < 4; i++) begin
            run_sched(vecs[i].dec, vecs[i].c, vecs[i].d, 0, k0, k15, dcyc);
            check($sformatf("vec%0d_k0", i), k0, vecs[i].k0);
            check($sformatf("vec%0d_k15", i), k15, vecs[i].k15);
            check($sformatf("vec%0d_done", i), dcyc, vecs[i].done_cyc);
        end

        // Five-cycle stall on round 3.
        run_sched(1'b0, 28'hF0CCAAF, 28'h556678F, 2, k0, k15, dcyc);
        check("stall_k0", k0, 48'h1B02EFFC7072);
        check("stall_k15", k15, 48'hCB3D8B0E17F5);
        check("stall_done", dcyc, 38);

        // Reset during round 7 aborts without DONE.
        @(negedge clk);
        bus.START = 1'b1; bus.DECRYPT = 1'b0; bus.C_IN = 28'hF0CCAAF; bus.D_IN = 28'h556678F;
        bus.ROUND_READY = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            bus.START = 1'b0;
            if (bus.ROUND_KEY_VALID && bus.ROUND_NUM == 4'd7) seen = 1'b1;
        end
        check("reach_round7", seen, 1);
        rst = 1'b1;
        bus.START = 1'b1;
        @(negedge clk);
        check("abort_valid", bus.ROUND_KEY_VALID, 0);
        check("abort_key", bus.ROUND_KEY, 0);
        check("abort_num", bus.ROUND_NUM, 0);
        check("abort_busy", bus.BUSY, 0);
        check("abort_done", bus.DONE, 0);
        rst = 1'b0;
        bus.START = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.DONE || bus.BUSY) stray = 1'b1;
        end
        check("no_done_after_abort", stray, 0);
        run_sched(1'b0, 28'hF0CCAAF, 28'h556678F, 0, k0, k15, dcyc);
        check("restart_k15", k15, 48'hCB3D8B0E17F5);

        // Random keys, random ready, START and input noise while busy.
        repeat (6) begin
            rc   = 28'($urandom);
            rd   = 28'($urandom);
            rdec = 1'($urandom_range(0, 1));
            run_sched(rdec, rc, rd, 1, k0, k15, dcyc);
            check("rand_k0", k0, model_key(rc, rd, rdec, 0));
            check("rand_k15", k15, model_key(rc, rd, rdec, 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
